// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed common-anode 7-segment scanner. Takes a
//               snapshot of the packed nibble array once per frame, walks
//               the digits with a refresh prescaler, hex-decodes each entry
//               and drives active-low anodes and cathodes.
//               Optional feature macro: SEG7_BLANK_EN (blank digits at or
//               above the captured valid count).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DEPTH       = 4,
    parameter int WIDTH       = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DEPTH-1:0][WIDTH-1:0]   digits,
    input  logic [$clog2(DEPTH):0]        valid_cnt,
    input  logic                          enable,
    output logic [DEPTH-1:0]              an,
    output logic [6:0]                    seg,
    output logic                          scan_tick
);

    localparam int c_IDX_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_IDX_W + 1;
    localparam int c_PCNT_W = $clog2(REFRESH_DIV);

    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DEPTH - 1);
    localparam logic [6:0]          c_SEG_OFF   = 7'h7F;

    // Scan state
    logic [c_PCNT_W-1:0]      r_pcnt;
    logic [c_IDX_W-1:0]       r_idx;
    logic [DEPTH-1:0][3:0]    r_snap;

    // Registered outputs
    logic [DEPTH-1:0]         r_an;
    logic [6:0]               r_seg;
    logic                     r_scan_tick;

    // Combinational helpers
    logic [DEPTH-1:0][3:0]    w_digits_ext;
    logic                     w_slot_end;
    logic                     w_guard;
    logic                     w_frame_start;
    logic [3:0]               w_cur_nib;
    logic [6:0]               w_seg_dec;
    logic [DEPTH-1:0]         w_an_lit;
    logic                     w_digit_blank;

    // Zero-extend every entry to a full nibble so the decoder is width-agnostic
    for (genvar k = 0; k < DEPTH; k++) begin : g_ext
        if (WIDTH >= 4) begin : g_full
            assign w_digits_ext[k] = digits[k][3:0];
        end else begin : g_pad
            assign w_digits_ext[k] = {{(4 - WIDTH){1'b0}}, digits[k]};
        end
    end

    assign w_slot_end    = (r_pcnt == c_PCNT_LAST);
    assign w_guard       = (r_pcnt == '0);
    assign w_frame_start = enable && w_guard && (r_idx == '0);
    assign w_cur_nib     = r_snap[r_idx];

`ifdef SEG7_BLANK_EN
    logic [c_CNT_W-1:0] r_snap_cnt;
    logic [c_CNT_W-1:0] w_cnt_sat;

    // Counts above the display depth are clamped so every digit stays visible
    assign w_cnt_sat     = (valid_cnt > c_CNT_W'(DEPTH)) ? c_CNT_W'(DEPTH) : valid_cnt;
    assign w_digit_blank = ({1'b0, r_idx} >= r_snap_cnt);

    // Captured valid count travels with the frame snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_cnt <= '0;
        end else if (w_frame_start) begin
            r_snap_cnt <= w_cnt_sat;
        end
    end
`else
    // Without blanking every digit is decoded; valid_cnt has no effect
    logic w_unused_valid_cnt;
    assign w_unused_valid_cnt = ^valid_cnt;
    assign w_digit_blank      = 1'b0;
`endif

    // Prescaler and digit index: advance only while scanning is enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
            r_idx  <= '0;
        end else if (enable) begin
            if (w_slot_end) begin
                r_pcnt <= '0;
                r_idx  <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

    // Frame snapshot: captured only at frame start so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_frame_start) begin
            r_snap <= w_digits_ext;
        end
    end

    // One-hot-low anode pattern for the current digit index
    always_comb begin
        w_an_lit = '1;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_an_lit[k] = 1'b0;
            end
        end
    end

    // Hex decode to active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_seg_dec = c_SEG_OFF;
        case (w_cur_nib)
            4'h0: w_seg_dec = 7'h40;
            4'h1: w_seg_dec = 7'h79;
            4'h2: w_seg_dec = 7'h24;
            4'h3: w_seg_dec = 7'h30;
            4'h4: w_seg_dec = 7'h19;
            4'h5: w_seg_dec = 7'h12;
            4'h6: w_seg_dec = 7'h02;
            4'h7: w_seg_dec = 7'h78;
            4'h8: w_seg_dec = 7'h00;
            4'h9: w_seg_dec = 7'h10;
            4'hA: w_seg_dec = 7'h08;
            4'hB: w_seg_dec = 7'h03;
            4'hC: w_seg_dec = 7'h46;
            4'hD: w_seg_dec = 7'h21;
            4'hE: w_seg_dec = 7'h06;
            4'hF: w_seg_dec = 7'h0E;
            default: w_seg_dec = c_SEG_OFF;
        endcase
    end

    // Output register: the first cycle of each slot is an all-off guard so
    // the previous digit's cathodes never ghost onto the newly selected anode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an        <= '1;
            r_seg       <= c_SEG_OFF;
            r_scan_tick <= 1'b0;
        end else if (!enable) begin
            r_an        <= '1;
            r_seg       <= c_SEG_OFF;
            r_scan_tick <= 1'b0;
        end else begin
            r_scan_tick <= w_slot_end;
            if (w_guard) begin
                r_an  <= '1;
                r_seg <= c_SEG_OFF;
            end else begin
                r_an  <= w_an_lit;
                r_seg <= w_digit_blank ? c_SEG_OFF : w_seg_dec;
            end
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign scan_tick = r_scan_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver. A frame-position
//               model (enabled cycles since frame start, split into digit and
//               slot offset by division) predicts every registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;
    localparam int RDIV  = 4;
    localparam int FRAME = DEPTH * RDIV;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic                        clk = 1'b0;
    logic                        rst;
    logic [DEPTH-1:0][WIDTH-1:0] digits;
    logic [2:0]                  valid_cnt;
    logic                        enable;
    logic [DEPTH-1:0]            an;
    logic [6:0]                  seg;
    logic                        scan_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int         m_pos;
    int         m_snap [DEPTH];
    int         m_cnt;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_tick;
    bit         e_seg_chk;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DEPTH       (DEPTH),
        .WIDTH       (WIDTH),
        .REFRESH_DIV (RDIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .valid_cnt (valid_cnt),
        .enable    (enable),
        .an        (an),
        .seg       (seg),
        .scan_tick (scan_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict next-cycle outputs from current inputs, clock once, compare
    task automatic step();
        int d;
        int s;
        if (rst) begin
            m_pos     = 0;
            e_an      = '1;
            e_seg     = 7'h7F;
            e_tick    = 1'b0;
            e_seg_chk = 1'b1;
        end else if (!enable) begin
            e_an      = '1;
            e_seg     = 7'h7F;
            e_tick    = 1'b0;
            e_seg_chk = 1'b1;
        end else begin
            d = m_pos / RDIV;
            s = m_pos % RDIV;
            if (m_pos == 0) begin
                for (int k = 0; k < DEPTH; k++) m_snap[k] = int'(digits[k]);
                m_cnt = (int'(valid_cnt) > DEPTH) ? DEPTH : int'(valid_cnt);
            end
            e_tick = (s == RDIV - 1);
            if (s == 0) begin
                e_an      = '1;
                e_seg_chk = 1'b0;
            end else begin
                e_an      = ~(4'b0001 << d);
                e_seg_chk = 1'b1;
                e_seg     = HEX[m_snap[d]];
`ifdef SEG7_BLANK_EN
                if (d >= m_cnt) e_seg = 7'h7F;
`endif
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("scan_tick", 32'(scan_tick), 32'(e_tick));
        if (e_seg_chk) check("seg", 32'(seg), 32'(e_seg));
    endtask

    // Step until the model reaches a frame position, with a cycle budget
    task automatic goto_pos(input int target);
        int n;
        n = 0;
        while (m_pos != target && n < 4 * FRAME) begin
            step();
            n++;
        end
        check("goto_pos_reached", 32'(m_pos), 32'(target));
    endtask

    initial begin
        int first_tick;
        int ticks;

        m_pos = 0;
        m_cnt = 0;
        for (int k = 0; k < DEPTH; k++) m_snap[k] = 0;

        // Reset held for three cycles
        rst       = 1'b1;
        enable    = 1'b1;
        digits    = 16'h3210;
        valid_cnt = 3'd4;
        repeat (3) step();

        // First tick four cycles after release
        rst        = 1'b0;
        first_tick = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (scan_tick === 1'b1) begin
                first_tick = i;
                break;
            end
        end
        check("first_tick_latency", 32'(first_tick), 32'd4);

        // Steady scan of 0..3 over two frames
        repeat (2 * FRAME) step();

        // Mid-frame digit change stays invisible until the next frame
        goto_pos(5);
        digits = 16'hFFFF;
        repeat (2 * FRAME) step();

        // Partial valid count
        digits    = 16'h9876;
        valid_cnt = 3'd2;
        goto_pos(0);
        repeat (FRAME + 2) step();

        // Enable low for ten cycles mid-slot at digit 2
        digits    = 16'h5A3C;
        valid_cnt = 3'd4;
        goto_pos(2 * RDIV + 1);
        enable = 1'b0;
        ticks  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (scan_tick !== 1'b0) ticks++;
        end
        check("no_tick_while_disabled", 32'(ticks), 32'd0);
        enable = 1'b1;
        repeat (FRAME) step();

        // Reset mid-frame at digit 3, then fresh snapshot
        goto_pos(3 * RDIV + 2);
        rst = 1'b1;
        step();
        rst       = 1'b0;
        digits    = 16'hB2D7;
        valid_cnt = 3'd4;
        step();
        step();
        check("post_reset_digit0_an", 32'(an), 32'hE);
        check("post_reset_digit0_seg", 32'(seg), 32'(HEX[7]));
        repeat (FRAME) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            valid_cnt = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) digits = 16'($urandom);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
